// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder and its full-adder cell.
package serial_adder_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_full_adder.sv
// Combinational full-adder cell: two half adders chained, carries merged with an OR.
module serial_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic sum1, car1, car2;

  student_half_adder u_ha1 (
    .a     (x),
    .b     (y),
    .sum   (sum1),
    .carry (car1)
  );

  student_half_adder u_ha2 (
    .a     (sum1),
    .b     (cin),
    .sum   (s),
    .carry (car2)
  );

  assign cout = car1 | car2;

endmodule

// File: rtl/student_half_adder.sv
// One-bit half adder: the basic cell the full-adder is built from.
module student_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, with a start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load;
  logic              fa_s, fa_c;

  serial_full_adder u_fa (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = start;
      RUN: begin
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = DONE;
      end
      DONE: begin
        // A start in the done cycle is accepted for back-to-back throughput.
        load = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      ra_d    = a;
      rb_d    = b;
      sum_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  // carry holds its final value after RUN and is cleared on every accepted start.
  assign cout = carry_q;

endmodule
